// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM encoding, playfield geometry, ball/paddle sizes and centre point.
// Used by ball_ctrl, the paddle blocks and the renderer.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_h_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_v_t;

    // One spare bit above the 10-bit screen coordinates so that sums never wrap.
    typedef logic [10:0] wide_t;

    localparam wide_t LEFT_BOUND  = 11'd20;
    localparam wide_t RIGHT_BOUND = 11'd620;
    localparam wide_t TOP_BOUND   = 11'd40;
    localparam wide_t BOT_BOUND   = 11'd470;
    localparam wide_t BALL_R      = 11'd4;
    localparam wide_t PADDLE_W    = 11'd8;
    localparam wide_t PADDLE_H    = 11'd48;
    localparam wide_t CENTRE_H    = 11'd320;
    localparam wide_t CENTRE_V    = 11'd255;

    localparam wide_t LEFT_FACE  = LEFT_BOUND + PADDLE_W + BALL_R;
    localparam wide_t RIGHT_FACE = RIGHT_BOUND - PADDLE_W - BALL_R;

    localparam int             SPEED_W   = 4;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 4'd6;

    function automatic wide_t widen(input logic [9:0] x);
        return {1'b0, x};
    endfunction

    // Inclusive vertical window [pad_top-BALL_R, pad_top+PADDLE_H+BALL_R], written without subtraction.
    function automatic logic in_window(input wide_t ball_v, input wide_t pad_top);
        return (ball_v + BALL_R >= pad_top) && (ball_v <= pad_top + PADDLE_H + BALL_R);
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running game-tick divider: tick is a one-clk enable every 2**DIV_BITS cycles.
module pong_tick_gen #(
    parameter int DIV_BITS = 20
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [DIV_BITS-1:0] cnt;

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + 1'b1;
    end

    assign tick = &cnt;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball motion engine: moves the ball once per tick, reflects off walls/paddles, flags goals.
// Optional SPEEDUP_EN: every paddle hit raises horizontal speed by one, capped at SPEED_MAX.
module ball_ctrl
    import pong_pkg::*;
#(
    parameter int DIV_BITS   = 20,
    parameter int SPEED_H0   = 2,
    parameter int SPEED_V0   = 1,
    parameter int SCORE_HOLD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serve,
    input  logic [9:0] p1_Pos_V,
    input  logic [9:0] p2_Pos_V,
    output logic [9:0] ball_Pos_H,
    output logic [9:0] ball_Pos_V,
    output logic       p1_goal,
    output logic       p2_goal,
    output logic       in_play
);

    localparam int HOLD_W = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;

    logic               tick;
    state_t             state, state_nxt;
    dir_h_t             dir_h, dir_h_upd, serve_dir;
    dir_v_t             dir_v, dir_v_upd;
    logic [SPEED_W-1:0] speed_h, speed_v;
    logic [HOLD_W-1:0]  hold_cnt;
    wide_t              pos_h, pos_v, nxt_h, nxt_v;
    logic [9:0]         h_upd, v_upd;
    logic               hit_l, hit_r, goal_l, goal_r, hold_done;

    pong_tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign pos_h     = widen(ball_Pos_H);
    assign pos_v     = widen(ball_Pos_V);
    assign hold_done = (hold_cnt == HOLD_W'(SCORE_HOLD - 1));

    // Candidate move for this tick; leftward/upward moves saturate at 0 instead of wrapping.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        nxt_h     = '0;
        nxt_v     = '0;
        h_upd     = '0;
        v_upd     = '0;
        dir_h_upd = dir_h;
        dir_v_upd = dir_v;

        if (dir_h == DIR_RIGHT)          nxt_h = pos_h + wide_t'(speed_h);
        else if (pos_h > wide_t'(speed_h)) nxt_h = pos_h - wide_t'(speed_h);
        if (dir_v == DIR_DOWN)           nxt_v = pos_v + wide_t'(speed_v);
        else if (pos_v > wide_t'(speed_v)) nxt_v = pos_v - wide_t'(speed_v);

        v_upd = nxt_v[9:0];
        if (dir_v == DIR_UP && nxt_v <= TOP_BOUND + BALL_R) begin
            v_upd     = 10'(TOP_BOUND + BALL_R);
            dir_v_upd = DIR_DOWN;
        end else if (dir_v == DIR_DOWN && nxt_v + BALL_R >= BOT_BOUND) begin
            v_upd     = 10'(BOT_BOUND - BALL_R);
            dir_v_upd = DIR_UP;
        end

        hit_l = (dir_h == DIR_LEFT)  && (nxt_h <= LEFT_FACE)  && in_window(pos_v, widen(p1_Pos_V));
        hit_r = (dir_h == DIR_RIGHT) && (nxt_h >= RIGHT_FACE) && in_window(pos_v, widen(p2_Pos_V));

        h_upd = nxt_h[9:0];
        if (hit_l) begin
            h_upd     = LEFT_FACE[9:0];
            dir_h_upd = DIR_RIGHT;
        end else if (hit_r) begin
            h_upd     = RIGHT_FACE[9:0];
            dir_h_upd = DIR_LEFT;
        end

        // A paddle hit has already turned the ball around, so it cannot also score.
        goal_l = (dir_h_upd == DIR_LEFT)  && (nxt_h <= LEFT_BOUND + BALL_R);
        goal_r = (dir_h_upd == DIR_RIGHT) && (nxt_h + BALL_R >= RIGHT_BOUND);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SERVE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                SERVE:   if (serve) state_nxt = PLAY;
                PLAY:    if (goal_l || goal_r) state_nxt = SCORED;
                SCORED:  if (hold_done) state_nxt = SERVE;
                default: state_nxt = SERVE;
            endcase
        end
    end

    always_comb begin
        in_play = (state == PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ball_Pos_H <= CENTRE_H[9:0];
            ball_Pos_V <= CENTRE_V[9:0];
            dir_h      <= DIR_RIGHT;
            dir_v      <= DIR_DOWN;
            serve_dir  <= DIR_RIGHT;
            speed_h    <= SPEED_W'(SPEED_H0);
            speed_v    <= SPEED_W'(SPEED_V0);
            hold_cnt   <= '0;
            p1_goal    <= 1'b0;
            p2_goal    <= 1'b0;
        end else begin
            p1_goal <= 1'b0;
            p2_goal <= 1'b0;
            if (tick) begin
                case (state)
                    SERVE: begin
                        ball_Pos_H <= CENTRE_H[9:0];
                        ball_Pos_V <= CENTRE_V[9:0];
                        dir_h      <= serve_dir;
                        speed_h    <= SPEED_W'(SPEED_H0);
                        speed_v    <= SPEED_W'(SPEED_V0);
                    end
                    PLAY: begin
                        if (goal_l || goal_r) begin
                            p2_goal   <= goal_l;
                            p1_goal   <= goal_r;
                            serve_dir <= (serve_dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
                            hold_cnt  <= '0;
                        end else begin
                            ball_Pos_H <= h_upd;
                            ball_Pos_V <= v_upd;
                            dir_h      <= dir_h_upd;
                            dir_v      <= dir_v_upd;
`ifdef SPEEDUP_EN
                            if (hit_l || hit_r)
                                speed_h <= (speed_h >= SPEED_MAX) ? SPEED_MAX : speed_h + 1'b1;
`endif
                        end
                    end
                    SCORED: begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_done) begin
                            ball_Pos_H <= CENTRE_H[9:0];
                            ball_Pos_V <= CENTRE_V[9:0];
                            dir_h      <= serve_dir;
                            speed_h    <= SPEED_W'(SPEED_H0);
                            speed_v    <= SPEED_W'(SPEED_V0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
